// File: rtl/node_power_seq.sv
// ---------------------------------------------------------------------------
// node_power_seq
//
// Power/reset sequencer for one compute node. Converts the self-awareness
// wake level (activate) and the detector's end-of-task pulse (fin) into a
// clean clock-gater enable and core reset:
//   wake     : clock on, core held in reset for RESET_HOLD_CYCLES, then run
//   shutdown : block new AR/AW requests, drain outstanding AXI traffic
//              (bounded by DRAIN_TIMEOUT), reset the core with the clock
//              still running for two cycles, then gate the clock.
//
// Ports
//   clk          in   node clock (ungated)
//   res_n        in   synchronous active-low reset
//   activate     in   wake request level
//   fin          in   single-cycle end-of-task pulse
//   aw/ar/b/r valid/ready  in  core-side AXI-light handshakes (observed)
//   clk_en       out  enable to the clock gater
//   core_res_n   out  core/detector reset, active-low
//   hold_req     out  suppress core awvalid/arvalid upstream
//   busy         out  high in every state except OFF
//   timeout      out  sticky: a drain was ended by the timeout
//   outstanding  out  outstanding AXI transaction count
// ---------------------------------------------------------------------------
module node_power_seq #(
    parameter int RESET_HOLD_CYCLES = 4,    // 1..255
    parameter int DRAIN_TIMEOUT     = 255,  // 0 disables the drain timeout
    parameter int OUTST_WIDTH       = 4
) (
    input  logic                   clk,
    input  logic                   res_n,
    input  logic                   activate,
    input  logic                   fin,
    input  logic                   awvalid,
    input  logic                   awready,
    input  logic                   arvalid,
    input  logic                   arready,
    input  logic                   bvalid,
    input  logic                   bready,
    input  logic                   rvalid,
    input  logic                   rready,
    output logic                   clk_en,
    output logic                   core_res_n,
    output logic                   hold_req,
    output logic                   busy,
    output logic                   timeout,
    output logic [OUTST_WIDTH-1:0] outstanding
);

    typedef enum logic [2:0] {
        S_OFF,
        S_WAKE,
        S_RUN,
        S_DRAIN,
        S_QUIESCE
    } state_t;

    // One shared cycle counter serves WAKE hold, DRAIN timeout and QUIESCE
    // length; it is zeroed whenever a state is entered.
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int CW = (TW > 8) ? TW : 8;

    localparam logic [OUTST_WIDTH+1:0] OMAX = {2'b00, {OUTST_WIDTH{1'b1}}};

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            act_q;
    logic            pend_wake, pend_next;
    logic            wake_edge, act_fall;
    logic            ar_hs, aw_hs, r_hs, b_hs;
    logic            drain_idle;
    logic            drain_expired;
    logic            timeout_hit;
    logic            enter_wake;

    logic [1:0]               inc, dec;
    logic [OUTST_WIDTH+1:0]   up, dec_ext, diff;
    logic [OUTST_WIDTH-1:0]   outst_sat, outst_next;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    assign wake_edge = activate & ~act_q;
    assign act_fall  = ~activate & act_q;

    assign ar_hs = arvalid & arready;
    assign aw_hs = awvalid & awready;
    assign r_hs  = rvalid & rready;
    assign b_hs  = bvalid & bready;

    // A request handshake in the same cycle means the counter is about to
    // rise, so a zero count alone is not enough to leave DRAIN.
    assign drain_idle = (outstanding == '0) && !ar_hs && !aw_hs;

    if (DRAIN_TIMEOUT > 0) begin : g_timeout
        assign drain_expired = (cnt == CW'(DRAIN_TIMEOUT - 1));
    end else begin : g_no_timeout
        assign drain_expired = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        cnt_next    = cnt + 1'b1;
        pend_next   = pend_wake;
        timeout_hit = 1'b0;

        case (state)
            S_OFF: begin
                cnt_next = '0;
                if (wake_edge || pend_wake) begin
                    state_next = S_WAKE;
                    pend_next  = 1'b0;
                end
            end

            S_WAKE: begin
                // fin and further wake edges are ignored while in reset hold
                if (cnt == CW'(RESET_HOLD_CYCLES - 1)) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
                end
            end

            S_RUN: begin
                cnt_next = '0;
                if (fin || act_fall)
                    state_next = S_DRAIN;
            end

            S_DRAIN: begin
                if (wake_edge)
                    pend_next = 1'b1;
                // A clean drain wins over a coincident timeout.
                if (drain_idle) begin
                    state_next = S_QUIESCE;
                    cnt_next   = '0;
                end else if (drain_expired) begin
                    state_next  = S_QUIESCE;
                    cnt_next    = '0;
                    timeout_hit = 1'b1;
                end
            end

            S_QUIESCE: begin
                if (wake_edge)
                    pend_next = 1'b1;
                if (cnt == CW'(1)) begin
                    state_next = S_OFF;
                    cnt_next   = '0;
                end
            end

            default: begin
                state_next = S_OFF;
                cnt_next   = '0;
            end
        endcase
    end

    assign enter_wake = (state == S_OFF) && (state_next == S_WAKE);

    // -----------------------------------------------------------------------
    // Outstanding counter: net -2..+2 per cycle, saturating at both ends.
    // Computed two bits wider so neither overflow nor underflow wraps.
    // -----------------------------------------------------------------------
    always_comb begin
        inc     = {1'b0, ar_hs} + {1'b0, aw_hs};
        dec     = {1'b0, r_hs} + {1'b0, b_hs};
        up      = {2'b00, outstanding} + {{OUTST_WIDTH{1'b0}}, inc};
        dec_ext = {{OUTST_WIDTH{1'b0}}, dec};
        diff    = up - dec_ext;

        if (up < dec_ext)
            outst_sat = '0;
        else if (diff > OMAX)
            outst_sat = {OUTST_WIDTH{1'b1}};
        else
            outst_sat = diff[OUTST_WIDTH-1:0];

        // A fresh wake starts from a clean count; a timed-out drain abandons
        // whatever the core still had in flight.
        if (enter_wake || timeout_hit)
            outst_next = '0;
        else
            outst_next = outst_sat;
    end

    // -----------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from state_next so
    // they change on the same edge as the state itself.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state       <= S_OFF;
            cnt         <= '0;
            act_q       <= 1'b0;
            pend_wake   <= 1'b0;
            outstanding <= '0;
            timeout     <= 1'b0;
            clk_en      <= 1'b0;
            core_res_n  <= 1'b0;
            hold_req    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            act_q       <= activate;
            pend_wake   <= pend_next;
            outstanding <= outst_next;
            timeout     <= timeout | timeout_hit;
            clk_en      <= (state_next != S_OFF);
            busy        <= (state_next != S_OFF);
            core_res_n  <= (state_next == S_RUN) || (state_next == S_DRAIN);
            hold_req    <= (state_next == S_DRAIN) || (state_next == S_QUIESCE);
        end
    end

endmodule
